// File: rtl/leaf_pkt_pkg.sv
// Shared BFT packet layout for the leaf egress path: field positions, widths,
// the packet struct and the default sizing constants used by the packer.
package leaf_pkt_pkg;

  localparam int PKT_W     = 49;
  localparam int PAYLOAD_W = 32;
  localparam int LEAF_W    = 5;
  localparam int PORT_W    = 4;
  localparam int ADDR_W    = 7;

  localparam int VALID_BIT = 48;
  localparam int LEAF_LSB  = 43;
  localparam int PORT_LSB  = 39;
  localparam int ADDR_LSB  = 32;

  localparam int DEF_NUM_OUT_PORTS     = 4;
  localparam int DEF_FREESPACE_UPDATE  = 64;
  localparam int DEF_INIT_CREDITS      = 128;

  // Field order matches the bit map: valid on top, payload at the bottom.
  typedef struct packed {
    logic              valid;
    logic [LEAF_W-1:0] dest_leaf;
    logic [PORT_W-1:0] dest_port;
    logic [ADDR_W-1:0] seq;
    logic [PAYLOAD_W-1:0] payload;
  } packet_t;

endpackage

// File: rtl/leaf_out_packer_if.sv
// User-kernel output streams and the BFT-facing packet port of the leaf packer.
interface leaf_out_packer_if #(
  parameter int NUM_OUT_PORTS = 4,
  parameter int PAYLOAD_BITS  = 32,
  parameter int PACKET_BITS   = 49
);
  // Handshakes: a user word moves when vld_user2interface[i] & ack_interface2user[i]
  // in the same cycle; a packet moves when dout_packet[48] & dout_ready.
  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface;
  logic [NUM_OUT_PORTS-1:0]              vld_user2interface;
  logic [NUM_OUT_PORTS-1:0]              ack_interface2user;
  logic [PACKET_BITS-1:0]                dout_packet;
  logic                                  dout_ready;

  modport master (
    output din_leaf_user2interface, vld_user2interface, dout_ready,
    input  ack_interface2user, dout_packet
  );

  modport slave (
    input  din_leaf_user2interface, vld_user2interface, dout_ready,
    output ack_interface2user, dout_packet
  );
endinterface

// File: rtl/leaf_out_packer_rr_arbiter.sv
// Round-robin arbiter: grants the first set request scanning upward from ptr.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic [NUM_REQ-1:0] req_rot;
  logic [NUM_REQ-1:0] grant_rot;

  // Rotate so ptr sits at bit 0, pick the lowest request, rotate back.
  always_comb begin
    req_rot   = NUM_REQ'({req, req} >> ptr);
    grant_rot = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        grant_rot    = '0;
        grant_rot[k] = 1'b1;
      end
    end
    grant = NUM_REQ'(({grant_rot, grant_rot} << ptr) >> NUM_REQ);
  end

endmodule

// File: rtl/leaf_out_packer.sv
// Leaf egress packer: round-robin over user output streams, tags each word with
// its destination and per-port sequence number, and registers one packet out.
module leaf_out_packer
  import leaf_pkt_pkg::*;
#(
  parameter int PACKET_BITS           = PKT_W,
  parameter int PAYLOAD_BITS          = PAYLOAD_W,
  parameter int NUM_LEAF_BITS         = LEAF_W,
  parameter int NUM_PORT_BITS         = PORT_W,
  parameter int NUM_ADDR_BITS         = ADDR_W,
  parameter int NUM_OUT_PORTS         = DEF_NUM_OUT_PORTS,
  parameter int FREESPACE_UPDATE_SIZE = DEF_FREESPACE_UPDATE,
  parameter int INIT_CREDITS          = DEF_INIT_CREDITS
) (
  input  logic                     clk,
  input  logic                     reset_n,
  leaf_out_packer_if.slave         bus,
  input  logic                     cfg_vld,
  input  logic [NUM_PORT_BITS-1:0] cfg_port,
  input  logic [NUM_LEAF_BITS-1:0] cfg_dest_leaf,
  input  logic [NUM_PORT_BITS-1:0] cfg_dest_port,
  input  logic                     credit_vld,
  input  logic [NUM_PORT_BITS-1:0] credit_port
);

  localparam int PTR_W    = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam int CREDIT_W = $clog2(INIT_CREDITS) + 1;
  localparam logic [CREDIT_W:0] CREDIT_MAX  = (CREDIT_W + 1)'(INIT_CREDITS);
  localparam logic [CREDIT_W:0] CREDIT_STEP = (CREDIT_W + 1)'(FREESPACE_UPDATE_SIZE);
  localparam logic [PTR_W-1:0]  LAST_PORT   = PTR_W'(NUM_OUT_PORTS - 1);

  logic [NUM_LEAF_BITS-1:0] dest_leaf  [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] dest_port  [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] seq_q      [NUM_OUT_PORTS];
  logic [CREDIT_W-1:0]      credit_q   [NUM_OUT_PORTS];
  logic [CREDIT_W-1:0]      credit_d   [NUM_OUT_PORTS];
  logic [NUM_OUT_PORTS-1:0] configured;
  logic [PTR_W-1:0]         ptr_q, ptr_d, win_idx;
  packet_t                  pkt_q, pkt_d;

  logic [NUM_OUT_PORTS-1:0] eligible, req, grant, cfg_hit, credit_hit;
  logic                     slot_free, transfer;
  logic [CREDIT_W:0]        credit_sum;

  // Out-of-range cfg_port / credit_port simply match no port.
  always_comb begin
    eligible   = '0;
    cfg_hit    = '0;
    credit_hit = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      eligible[i]   = bus.vld_user2interface[i] & configured[i] & (credit_q[i] != '0);
      cfg_hit[i]    = cfg_vld & (cfg_port == NUM_PORT_BITS'(i));
      credit_hit[i] = credit_vld & (credit_port == NUM_PORT_BITS'(i));
    end
  end

  assign slot_free = ~pkt_q.valid | bus.dout_ready;
  assign req       = slot_free ? eligible : '0;
  assign transfer  = |grant;

  rr_arbiter #(
    .NUM_REQ (NUM_OUT_PORTS),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req   (req),
    .ptr   (ptr_q),
    .grant (grant)
  );

  assign bus.ack_interface2user = grant;
  assign bus.dout_packet        = PACKET_BITS'(pkt_q);

  always_comb begin
    pkt_d   = pkt_q;
    win_idx = '0;
    if (slot_free) pkt_d.valid = 1'b0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (grant[i]) begin
        pkt_d.valid     = 1'b1;
        pkt_d.dest_leaf = dest_leaf[i];
        pkt_d.dest_port = dest_port[i];
        pkt_d.seq       = seq_q[i];
        pkt_d.payload   = bus.din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS];
        win_idx         = PTR_W'(i);
      end
    end
    ptr_d = ptr_q;
    if (transfer) ptr_d = (win_idx == LAST_PORT) ? '0 : win_idx + 1'b1;
  end

  // A return and a send in the same cycle net out before saturation.
  always_comb begin
    credit_sum = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      credit_sum = {1'b0, credit_q[i]}
                 + (credit_hit[i] ? CREDIT_STEP : '0)
                 - (grant[i] ? (CREDIT_W + 1)'(1) : '0);
      credit_d[i] = (credit_sum > CREDIT_MAX) ? CREDIT_MAX[CREDIT_W-1:0]
                                              : credit_sum[CREDIT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_q      <= '0;
      ptr_q      <= '0;
      configured <= '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        dest_leaf[i] <= '0;
        dest_port[i] <= '0;
        seq_q[i]     <= '0;
        credit_q[i]  <= CREDIT_W'(INIT_CREDITS);
      end
    end else begin
      pkt_q <= pkt_d;
      ptr_q <= ptr_d;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        credit_q[i] <= credit_d[i];
        // A config write wins over a same-cycle send; the send used the old entry.
        if (cfg_hit[i]) begin
          dest_leaf[i]  <= cfg_dest_leaf;
          dest_port[i]  <= cfg_dest_port;
          configured[i] <= 1'b1;
          seq_q[i]      <= '0;
        end else if (grant[i]) begin
          seq_q[i] <= seq_q[i] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_leaf_out_packer.sv
// Directed bench for leaf_out_packer with a reference model and packet scoreboard.
module tb_leaf_out_packer;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cfg_vld;
  logic [3:0] cfg_port;
  logic [4:0] cfg_dest_leaf;
  logic [3:0] cfg_dest_port;
  logic       credit_vld;
  logic [3:0] credit_port;

  always #5 clk = ~clk;

  leaf_out_packer_if #(.NUM_OUT_PORTS(N), .PAYLOAD_BITS(32), .PACKET_BITS(49)) bus ();

  leaf_out_packer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus           (bus),
    .cfg_vld       (cfg_vld),
    .cfg_port      (cfg_port),
    .cfg_dest_leaf (cfg_dest_leaf),
    .cfg_dest_port (cfg_dest_port),
    .credit_vld    (credit_vld),
    .credit_port   (credit_port)
  );

  // Reference model state
  logic [4:0]  m_leaf [N];
  logic [3:0]  m_port [N];
  logic [6:0]  m_seq  [N];
  int          m_credit [N];
  bit          m_cfgd [N];
  int          m_ptr;
  bit          m_valid;
  logic [48:0] m_pkt;
  int          grant_cnt [N];

  logic [48:0] exp_q [$];

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_leaf[i] = '0; m_port[i] = '0; m_seq[i] = '0;
      m_credit[i] = 128; m_cfgd[i] = 0; grant_cnt[i] = 0;
    end
    m_ptr = 0; m_valid = 0; m_pkt = '0;
    exp_q.delete();
  endtask

  task automatic clear_counts();
    for (int i = 0; i < N; i++) grant_cnt[i] = 0;
  endtask

  task automatic rand_words();
    bus.din_leaf_user2interface = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // One clock: check acks against the model before the edge, packet after it.
  task automatic step();
    logic [N-1:0] exp_ack;
    int  g;
    bit  slot_free;
    @(negedge clk);
    slot_free = !m_valid || bus.dout_ready;
    exp_ack = '0;
    g = -1;
    if (slot_free) begin
      for (int k = 0; k < N; k++) begin
        int p;
        p = (m_ptr + k) % N;
        if (g < 0 && bus.vld_user2interface[p] && m_cfgd[p] && m_credit[p] != 0) g = p;
      end
    end
    if (g >= 0) exp_ack[g] = 1'b1;
    check("ack", bus.ack_interface2user, exp_ack);
    if (g >= 0) begin
      exp_q.push_back({1'b1, m_leaf[g], m_port[g], m_seq[g],
                       bus.din_leaf_user2interface[g*32 +: 32]});
      m_seq[g]++;
      m_credit[g]--;
      m_ptr = (g + 1) % N;
      grant_cnt[g]++;
    end
    if (cfg_vld && cfg_port < N) begin
      m_leaf[cfg_port] = cfg_dest_leaf;
      m_port[cfg_port] = cfg_dest_port;
      m_cfgd[cfg_port] = 1;
      m_seq[cfg_port]  = '0;
    end
    if (credit_vld && credit_port < N) begin
      m_credit[credit_port] = m_credit[credit_port] + 64;
      if (m_credit[credit_port] > 128) m_credit[credit_port] = 128;
    end
    @(posedge clk);
    #1;
    if (g >= 0) begin
      m_pkt   = exp_q.pop_front();
      m_valid = 1;
      check("pkt", bus.dout_packet, m_pkt);
    end else if (slot_free) begin
      m_valid = 0;
      check("idle_valid", bus.dout_packet[48], 1'b0);
    end else begin
      check("held_pkt", bus.dout_packet, m_pkt);
    end
  endtask

  task automatic cfg_write(input int port, input int leaf, input int dport);
    cfg_vld = 1'b1;
    cfg_port = 4'(port);
    cfg_dest_leaf = 5'(leaf);
    cfg_dest_port = 4'(dport);
    step();
    cfg_vld = 1'b0;
  endtask

  task automatic credit_return(input int port);
    credit_vld = 1'b1;
    credit_port = 4'(port);
    step();
    credit_vld = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    cfg_vld = 1'b0; cfg_port = '0; cfg_dest_leaf = '0; cfg_dest_port = '0;
    credit_vld = 1'b0; credit_port = '0;
    bus.din_leaf_user2interface = '0;
    bus.vld_user2interface = '0;
    bus.dout_ready = 1'b1;
    model_reset();
    #1;
    check("reset_dout", bus.dout_packet, 49'h0);
    check("reset_ack", bus.ack_interface2user, 4'h0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;

    // Unconfigured port must not be acked.
    bus.vld_user2interface = 4'b0001;
    step();
    bus.vld_user2interface = '0;

    // Port 0 -> leaf 3 / port 2, three words back to back.
    cfg_write(0, 3, 2);
    bus.vld_user2interface = 4'b0001;
    bus.din_leaf_user2interface = 128'h0000000A;
    step();
    check("first_pkt_const", bus.dout_packet, 49'h1_1900_0000_000A);
    bus.din_leaf_user2interface = 128'h0000000B;
    step();
    bus.din_leaf_user2interface = 128'h0000000C;
    step();
    check("third_seq", bus.dout_packet[38:32], 7'd2);
    bus.vld_user2interface = '0;

    // Ignored out-of-range config write.
    cfg_write(7, 31, 15);

    // All four ports: fair round robin over 100 packets.
    for (int i = 0; i < N; i++) cfg_write(i, i + 1, i + 8);
    clear_counts();
    bus.vld_user2interface = 4'b1111;
    for (int i = 0; i < 100; i++) begin
      rand_words();
      step();
    end
    for (int i = 0; i < N; i++) check($sformatf("fair_port%0d", i), grant_cnt[i], 25);
    bus.vld_user2interface = '0;

    // Port 1 credit exhaustion and recovery.
    credit_return(1);
    credit_return(1);
    clear_counts();
    bus.vld_user2interface = 4'b0010;
    for (int i = 0; i < 135; i++) begin
      rand_words();
      step();
    end
    check("credit_exhaust_cnt", grant_cnt[1], 128);
    credit_vld = 1'b1; credit_port = 4'd9;
    step();
    credit_vld = 1'b0;
    step();
    check("oor_credit_ignored", grant_cnt[1], 128);
    credit_return(1);
    clear_counts();
    rand_words();
    step();
    check("credit_resume", grant_cnt[1], 1);
    for (int i = 0; i < 69; i++) begin
      rand_words();
      step();
    end
    check("credit_refill_cnt", grant_cnt[1], 64);
    bus.vld_user2interface = '0;

    // Back-pressure hold and release.
    bus.vld_user2interface = 4'b0001;
    rand_words();
    step();
    bus.dout_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_words();
      step();
    end
    check("bp_ack_zero", bus.ack_interface2user, 4'h0);
    bus.dout_ready = 1'b1;
    rand_words();
    step();
    rand_words();
    step();
    bus.vld_user2interface = '0;

    // Port 2 sequence wrap with periodic credits, then reconfigure mid-stream.
    clear_counts();
    bus.vld_user2interface = 4'b0100;
    for (int i = 0; i < 140; i++) begin
      rand_words();
      credit_vld = (i % 40 == 0);
      credit_port = 4'd2;
      step();
    end
    credit_vld = 1'b0;
    check("wrap_cnt", grant_cnt[2], 140);
    rand_words();
    cfg_write(2, 9, 5);
    rand_words();
    step();
    check("recfg_leaf", bus.dout_packet[47:43], 5'd9);
    check("recfg_port", bus.dout_packet[42:39], 4'd5);
    check("recfg_seq", bus.dout_packet[38:32], 7'd0);
    bus.vld_user2interface = '0;

    // Reset while a packet is held.
    bus.vld_user2interface = 4'b0001;
    rand_words();
    step();
    bus.dout_ready = 1'b0;
    bus.vld_user2interface = '0;
    step();
    #3;
    reset_n = 1'b0;
    #1;
    check("midreset_dout", bus.dout_packet, 49'h0);
    check("midreset_ack", bus.ack_interface2user, 4'h0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    bus.dout_ready = 1'b1;
    cfg_write(0, 3, 2);
    bus.vld_user2interface = 4'b0001;
    rand_words();
    step();
    check("post_reset_seq", bus.dout_packet[38:32], 7'd0);
    for (int i = 0; i < 134; i++) begin
      rand_words();
      step();
    end
    check("post_reset_credits", grant_cnt[0], 128);
    bus.vld_user2interface = '0;
    step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
